// File: rtl/vector_issue_ctrl_if.sv
// Issue-controller bus: instruction handshake, broadcast operands to the lanes,
// lane completion/read streams and the response beat.
interface vector_issue_ctrl_if #(
  parameter int els_p      = 8,
  parameter int vlen_p     = 8,
  parameter int vdw_p      = 8,
  parameter int lanes_p    = 4,
  parameter int op_width_p = 4
);
  localparam int v_addr_width_lp     = (els_p  > 1) ? $clog2(els_p)  : 1;
  localparam int local_addr_width_lp = (vlen_p > 1) ? $clog2(vlen_p) : 1;

  logic                            instr_v_i;
  logic                            instr_ready_o;
  logic [op_width_p-1:0]           instr_op_i;
  logic [v_addr_width_lp-1:0]      instr_vd_i;
  logic [v_addr_width_lp-1:0]      instr_vs1_i;
  logic [v_addr_width_lp-1:0]      instr_vs2_i;
  logic [local_addr_width_lp-1:0]  instr_offset_i;
  logic [vdw_p-1:0]                instr_scalar_i;
  logic [vdw_p-1:0]                instr_wdata_i;

  logic [op_width_p-1:0]           op_o;
  logic                            start_o;
  logic [local_addr_width_lp-1:0]  w_addr_offset_o;
  logic [vdw_p-1:0]                scalar_o;
  logic [vdw_p-1:0]                w_data_o;
  logic [v_addr_width_lp-1:0]      vd_o;
  logic [v_addr_width_lp-1:0]      vs1_o;
  logic [v_addr_width_lp-1:0]      vs2_o;

  logic [lanes_p-1:0]              lane_done_i;
  logic [lanes_p-1:0]              lane_v_i;
  logic [lanes_p*vdw_p-1:0]        lane_r_data_i;

  logic                            resp_v_o;
  logic [vlen_p*vdw_p-1:0]         resp_data_o;
  logic                            resp_yumi_i;

  // master: upstream issuer plus lane array; slave: the controller
  modport master (
    output instr_v_i, instr_op_i, instr_vd_i, instr_vs1_i, instr_vs2_i,
           instr_offset_i, instr_scalar_i, instr_wdata_i,
           lane_done_i, lane_v_i, lane_r_data_i, resp_yumi_i,
    input  instr_ready_o, op_o, start_o, w_addr_offset_o, scalar_o, w_data_o,
           vd_o, vs1_o, vs2_o, resp_v_o, resp_data_o
  );

  modport slave (
    input  instr_v_i, instr_op_i, instr_vd_i, instr_vs1_i, instr_vs2_i,
           instr_offset_i, instr_scalar_i, instr_wdata_i,
           lane_done_i, lane_v_i, lane_r_data_i, resp_yumi_i,
    output instr_ready_o, op_o, start_o, w_addr_offset_o, scalar_o, w_data_o,
           vd_o, vs1_o, vs2_o, resp_v_o, resp_data_o
  );
endinterface

// File: rtl/vector_issue_ctrl.sv
// Single-instruction vector issue controller: broadcast start, gather lane
// done bits, reassemble read data and return one response beat.
module vic_lane_buf #(
  parameter int vdw_p     = 8,
  parameter int beats_lp  = 2,
  parameter int beat_w_lp = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           clr,
  input  logic                           wr,
  input  logic [beat_w_lp-1:0]           beat,
  input  logic [vdw_p-1:0]               data,
  output logic [beats_lp-1:0][vdw_p-1:0] elems
);
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)  elems <= '0;
    else if (clr) elems <= '0;
    else if (wr) begin
      for (int b = 0; b < beats_lp; b++)
        if (beat == beat_w_lp'(b)) elems[b] <= data;
    end
  end
endmodule

module vector_issue_ctrl #(
  parameter int els_p      = 8,
  parameter int vlen_p     = 8,
  parameter int vdw_p      = 8,
  parameter int lanes_p    = 4,
  parameter int op_width_p = 4
) (
  input logic               clk_i,
  input logic               reset_i,
  vector_issue_ctrl_if.slave bus
);
  localparam int v_addr_width_lp     = (els_p  > 1) ? $clog2(els_p)  : 1;
  localparam int local_addr_width_lp = (vlen_p > 1) ? $clog2(vlen_p) : 1;
  localparam int beats_lp            = vlen_p / lanes_p;
  localparam int beat_w_lp           = $clog2(beats_lp + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [op_width_p-1:0] READ_OP = op_width_p'(4'b1000);

  typedef struct packed {
    logic [op_width_p-1:0]          op;
    logic [v_addr_width_lp-1:0]     vd;
    logic [v_addr_width_lp-1:0]     vs1;
    logic [v_addr_width_lp-1:0]     vs2;
    logic [local_addr_width_lp-1:0] offset;
    logic [vdw_p-1:0]               scalar;
    logic [vdw_p-1:0]               wdata;
  } operands_t;

  logic [1:0]           state_r, state_n;
  operands_t            ops_r;
  logic [lanes_p-1:0]   mask_r, mask_next;
  logic [beat_w_lp-1:0] beat_r;
  logic                 accept, collect, all_done;

  logic [lanes_p-1:0][beats_lp-1:0][vdw_p-1:0] lane_elems;
  logic [vlen_p*vdw_p-1:0]                     resp_data;
  logic                                        unused_lane_v;

  assign accept    = (state_r == IDLE) && bus.instr_v_i;
  assign mask_next = mask_r | bus.lane_done_i;
  assign all_done  = &mask_next;
  // lanes run in lockstep, so lane 0's valid paces every lane's beat
  assign collect   = (ops_r.op == READ_OP) && ((state_r == ISSUE) || (state_r == BUSY))
                     && bus.lane_v_i[0] && (beat_r < beat_w_lp'(beats_lp));
  assign unused_lane_v = ^bus.lane_v_i[lanes_p-1:1];

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (bus.instr_v_i)   state_n = ISSUE;
      ISSUE:                        state_n = BUSY;
      BUSY:    if (all_done)        state_n = RESP;
      RESP:    if (bus.resp_yumi_i) state_n = IDLE;
      default:                      state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      ops_r   <= '0;
      mask_r  <= '0;
      beat_r  <= '0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        ops_r  <= '{op: bus.instr_op_i, vd: bus.instr_vd_i, vs1: bus.instr_vs1_i,
                    vs2: bus.instr_vs2_i, offset: bus.instr_offset_i,
                    scalar: bus.instr_scalar_i, wdata: bus.instr_wdata_i};
        mask_r <= '0;
        beat_r <= '0;
      end else begin
        if (state_r == BUSY) mask_r <= mask_next;
        if (collect)         beat_r <= beat_r + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < lanes_p; i++) begin : g_lane
    vic_lane_buf #(.vdw_p(vdw_p), .beats_lp(beats_lp), .beat_w_lp(beat_w_lp)) u_buf (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr     (accept),
      .wr      (collect),
      .beat    (beat_r),
      .data    (bus.lane_r_data_i[i*vdw_p +: vdw_p]),
      .elems   (lane_elems[i])
    );
  end

  // element i + lanes_p*beat comes from lane i, beat slot 'beat'
  always_comb begin
    resp_data = '0;
    for (int i = 0; i < lanes_p; i++)
      for (int b = 0; b < beats_lp; b++)
        resp_data[(i + lanes_p*b)*vdw_p +: vdw_p] = lane_elems[i][b];
  end

  assign bus.instr_ready_o   = (state_r == IDLE);
  assign bus.start_o         = (state_r == ISSUE);
  assign bus.resp_v_o        = (state_r == RESP);
  assign bus.resp_data_o     = resp_data;
  assign bus.op_o            = ops_r.op;
  assign bus.vd_o            = ops_r.vd;
  assign bus.vs1_o           = ops_r.vs1;
  assign bus.vs2_o           = ops_r.vs2;
  assign bus.w_addr_offset_o = ops_r.offset;
  assign bus.scalar_o        = ops_r.scalar;
  assign bus.w_data_o        = ops_r.wdata;
endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Directed bench for vector_issue_ctrl (lanes_p=4, vlen_p=8, vdw_p=8).
module tb_vector_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_issue_ctrl_if bus ();
  vector_issue_ctrl dut (.clk_i(clk), .reset_i(rst), .bus(bus));

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs;
    bus.instr_v_i = 0; bus.instr_op_i = 0; bus.instr_vd_i = 0; bus.instr_vs1_i = 0;
    bus.instr_vs2_i = 0; bus.instr_offset_i = 0; bus.instr_scalar_i = 0;
    bus.instr_wdata_i = 0; bus.lane_done_i = 0; bus.lane_v_i = 0;
    bus.lane_r_data_i = 0; bus.resp_yumi_i = 0;
  endtask

  // drive one instruction in IDLE; returns in the ISSUE cycle (T+1)
  task automatic issue(input logic [3:0] op, input logic [2:0] vd, input logic [2:0] vs1,
                       input logic [2:0] vs2, input logic [2:0] off,
                       input logic [7:0] sc, input logic [7:0] wd);
    bus.instr_op_i = op; bus.instr_vd_i = vd; bus.instr_vs1_i = vs1; bus.instr_vs2_i = vs2;
    bus.instr_offset_i = off; bus.instr_scalar_i = sc; bus.instr_wdata_i = wd;
    bus.instr_v_i = 1;
    step;
    bus.instr_v_i = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    step;
    total_cnt++; if (bus.instr_ready_o !== 1'b1) $display("FAIL rst_ready got %b exp 1", bus.instr_ready_o); else pass_cnt++;
    total_cnt++; if (bus.start_o !== 1'b0) $display("FAIL rst_start got %b exp 0", bus.start_o); else pass_cnt++;
    total_cnt++; if (bus.resp_v_o !== 1'b0) $display("FAIL rst_resp_v got %b exp 0", bus.resp_v_o); else pass_cnt++;
    total_cnt++; if (bus.resp_data_o !== 64'h0) $display("FAIL rst_resp_data got %h exp 0", bus.resp_data_o); else pass_cnt++;
    total_cnt++; if ({bus.op_o, bus.vd_o, bus.vs1_o, bus.vs2_o, bus.w_addr_offset_o, bus.scalar_o, bus.w_data_o} !== 35'h0)
      $display("FAIL rst_operands got op=%h vd=%h sc=%h exp 0", bus.op_o, bus.vd_o, bus.scalar_o); else pass_cnt++;
    rst = 0;
    step;
    // abort mid-BUSY with a partial mask
    issue(4'b0000, 3'd6, 3'd1, 3'd1, 3'd0, 8'h00, 8'h00);
    step;
    bus.lane_done_i = 4'b0001;
    step;
    bus.lane_done_i = 4'b0000;
    #3 rst = 1;
    #1;
    total_cnt++; if (bus.instr_ready_o !== 1'b1) $display("FAIL midrst_ready got %b exp 1", bus.instr_ready_o); else pass_cnt++;
    total_cnt++; if (bus.start_o !== 1'b0) $display("FAIL midrst_start got %b exp 0", bus.start_o); else pass_cnt++;
    total_cnt++; if (bus.resp_v_o !== 1'b0) $display("FAIL midrst_resp_v got %b exp 0", bus.resp_v_o); else pass_cnt++;
    total_cnt++; if (bus.vd_o !== 3'd0) $display("FAIL midrst_vd got %h exp 0", bus.vd_o); else pass_cnt++;
    step;
    rst = 0;
    step;
    issue(4'b0000, 3'd2, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00);
    total_cnt++; if (bus.start_o !== 1'b1) $display("FAIL postrst_start got %b exp 1", bus.start_o); else pass_cnt++;
    step;
    bus.lane_done_i = 4'b1110;
    step;
    bus.lane_done_i = 4'b0000;
    total_cnt++; if (bus.resp_v_o !== 1'b0) $display("FAIL postrst_early_resp got %b exp 0", bus.resp_v_o); else pass_cnt++;
    bus.lane_done_i = 4'b0001;
    step;
    bus.lane_done_i = 4'b0000;
    total_cnt++; if (bus.resp_v_o !== 1'b1) $display("FAIL postrst_resp got %b exp 1", bus.resp_v_o); else pass_cnt++;
    bus.resp_yumi_i = 1;
    step;
    bus.resp_yumi_i = 0;
    total_cnt++; if (bus.instr_ready_o !== 1'b1) $display("FAIL postrst_idle got %b exp 1", bus.instr_ready_o); else pass_cnt++;
  endtask

  task automatic test_non_read;
    issue(4'b0000, 3'd3, 3'd1, 3'd2, 3'd0, 8'h00, 8'h00);
    for (int c = 1; c <= 8; c++) begin
      bus.lane_done_i = (c == 5) ? 4'b0011 : (c == 6) ? 4'b0100 : (c == 7) ? 4'b1000 : 4'b0000;
      bus.resp_yumi_i = (c == 8);
      total_cnt++; if (bus.start_o !== (c == 1)) $display("FAIL nr_start c=%0d got %b exp %b", c, bus.start_o, c == 1); else pass_cnt++;
      total_cnt++; if (bus.resp_v_o !== (c == 8)) $display("FAIL nr_resp_v c=%0d got %b exp %b", c, bus.resp_v_o, c == 8); else pass_cnt++;
      total_cnt++; if ({bus.vd_o, bus.vs1_o, bus.vs2_o} !== {3'd3, 3'd1, 3'd2})
        $display("FAIL nr_regs c=%0d got %0d/%0d/%0d exp 3/1/2", c, bus.vd_o, bus.vs1_o, bus.vs2_o); else pass_cnt++;
      if (c == 8) begin
        total_cnt++; if (bus.resp_data_o !== 64'h0) $display("FAIL nr_data got %h exp 0", bus.resp_data_o); else pass_cnt++;
      end
      step;
    end
    bus.lane_done_i = 0; bus.resp_yumi_i = 0;
    total_cnt++; if (bus.instr_ready_o !== 1'b1) $display("FAIL nr_idle got %b exp 1", bus.instr_ready_o); else pass_cnt++;
  endtask

  task automatic test_read_back_pressure;
    logic [63:0] exp_data;
    exp_data = 64'h13121110_03020100;
    issue(4'b1000, 3'd4, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00);
    bus.lane_v_i = 4'b1111; bus.lane_r_data_i = 32'h03020100;
    step;
    bus.lane_r_data_i = 32'h13121110;
    step;
    bus.lane_r_data_i = 32'hFFFFFFFF; bus.lane_done_i = 4'b1111;
    total_cnt++; if (bus.resp_v_o !== 1'b0) $display("FAIL rd_early_resp got %b exp 0", bus.resp_v_o); else pass_cnt++;
    step;
    bus.lane_done_i = 0; bus.lane_r_data_i = 32'hAAAAAAAA;
    total_cnt++; if (bus.resp_v_o !== 1'b1) $display("FAIL rd_resp_v got %b exp 1", bus.resp_v_o); else pass_cnt++;
    total_cnt++; if (bus.resp_data_o !== exp_data) $display("FAIL rd_data got %h exp %h", bus.resp_data_o, exp_data); else pass_cnt++;
    // a new instruction waits upstream while the response is back-pressured
    bus.instr_op_i = 4'b0001; bus.instr_vd_i = 3'd5; bus.instr_vs1_i = 3'd6; bus.instr_vs2_i = 3'd7;
    bus.instr_v_i = 1;
    for (int k = 0; k < 5; k++) begin
      total_cnt++; if (bus.resp_v_o !== 1'b1) $display("FAIL bp_resp_v k=%0d got %b exp 1", k, bus.resp_v_o); else pass_cnt++;
      total_cnt++; if (bus.resp_data_o !== exp_data) $display("FAIL bp_data k=%0d got %h exp %h", k, bus.resp_data_o, exp_data); else pass_cnt++;
      total_cnt++; if (bus.instr_ready_o !== 1'b0) $display("FAIL bp_ready k=%0d got %b exp 0", k, bus.instr_ready_o); else pass_cnt++;
      total_cnt++; if ({bus.op_o, bus.vd_o} !== {4'b1000, 3'd4}) $display("FAIL bp_hold k=%0d got op=%h vd=%0d exp op=8 vd=4", k, bus.op_o, bus.vd_o); else pass_cnt++;
      step;
    end
    bus.lane_v_i = 0;
    bus.resp_yumi_i = 1;
    step;
    bus.resp_yumi_i = 0;
    total_cnt++; if ({bus.instr_ready_o, bus.resp_v_o, bus.start_o} !== 3'b100)
      $display("FAIL bp_idle got rdy/rv/st=%b%b%b exp 100", bus.instr_ready_o, bus.resp_v_o, bus.start_o); else pass_cnt++;
    step;
    bus.instr_v_i = 0;
    total_cnt++; if (bus.start_o !== 1'b1) $display("FAIL bp_next_start got %b exp 1", bus.start_o); else pass_cnt++;
    total_cnt++; if ({bus.op_o, bus.vd_o, bus.vs1_o, bus.vs2_o} !== {4'b0001, 3'd5, 3'd6, 3'd7})
      $display("FAIL bp_next_ops got op=%h vd=%0d exp op=1 vd=5", bus.op_o, bus.vd_o); else pass_cnt++;
    step;
    bus.lane_done_i = 4'b1111;
    step;
    bus.lane_done_i = 0;
    total_cnt++; if (bus.resp_v_o !== 1'b1) $display("FAIL bp_next_resp got %b exp 1", bus.resp_v_o); else pass_cnt++;
    total_cnt++; if (bus.resp_data_o !== 64'h0) $display("FAIL bp_next_data got %h exp 0", bus.resp_data_o); else pass_cnt++;
    bus.resp_yumi_i = 1;
    step;
    bus.resp_yumi_i = 0;
  endtask

  task automatic test_stray_done;
    bus.lane_done_i = 4'b1111; bus.lane_v_i = 4'b1111;
    step;
    bus.lane_done_i = 0; bus.lane_v_i = 0;
    total_cnt++; if ({bus.instr_ready_o, bus.resp_v_o} !== 2'b10) $display("FAIL stray_idle got rdy/rv=%b%b exp 10", bus.instr_ready_o, bus.resp_v_o); else pass_cnt++;
    issue(4'b0010, 3'd1, 3'd1, 3'd1, 3'd0, 8'h00, 8'h00);
    step;
    total_cnt++; if (bus.resp_v_o !== 1'b0) $display("FAIL stray_c2 got %b exp 0", bus.resp_v_o); else pass_cnt++;
    step;
    total_cnt++; if (bus.resp_v_o !== 1'b0) $display("FAIL stray_c3 got %b exp 0", bus.resp_v_o); else pass_cnt++;
    bus.lane_done_i = 4'b1111;
    step;
    bus.lane_done_i = 0;
    total_cnt++; if (bus.resp_v_o !== 1'b1) $display("FAIL stray_resp got %b exp 1", bus.resp_v_o); else pass_cnt++;
    bus.resp_yumi_i = 1;
    step;
    bus.resp_yumi_i = 0;
  endtask

  task automatic test_fma;
    issue(4'b1111, 3'd1, 3'd2, 3'd3, 3'd2, 8'h05, 8'hA5);
    // yumi held high throughout: only the RESP cycle may consume it
    bus.resp_yumi_i = 1;
    for (int c = 1; c <= 4; c++) begin
      bus.lane_done_i = (c == 2) ? 4'b0011 : (c == 3) ? 4'b1100 : 4'b0000;
      total_cnt++; if ({bus.op_o, bus.w_addr_offset_o, bus.scalar_o, bus.w_data_o} !== {4'hF, 3'd2, 8'h05, 8'hA5})
        $display("FAIL fma_ops c=%0d got op=%h off=%0d sc=%h wd=%h exp F/2/05/A5", c, bus.op_o, bus.w_addr_offset_o, bus.scalar_o, bus.w_data_o); else pass_cnt++;
      total_cnt++; if (bus.start_o !== (c == 1)) $display("FAIL fma_start c=%0d got %b exp %b", c, bus.start_o, c == 1); else pass_cnt++;
      total_cnt++; if (bus.resp_v_o !== (c == 4)) $display("FAIL fma_resp_v c=%0d got %b exp %b", c, bus.resp_v_o, c == 4); else pass_cnt++;
      step;
    end
    bus.lane_done_i = 0; bus.resp_yumi_i = 0;
    total_cnt++; if ({bus.instr_ready_o, bus.resp_v_o} !== 2'b10) $display("FAIL fma_idle got rdy/rv=%b%b exp 10", bus.instr_ready_o, bus.resp_v_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_non_read();
    test_read_back_pressure();
    test_stray_done();
    test_fma();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/vector_issue_ctrl.md
# vector_issue_ctrl

Single-instruction issue controller sitting directly upstream of the `lanes_p` vector lanes. It accepts one vector instruction at a time over a valid/ready handshake and broadcasts a one-cycle start with held-stable operands to all lanes. It then waits until every lane has reported done and returns one response beat. For read ops (op 4'b1000) the response carries the full vector reassembled from the per-lane read streams.

## Interface
- `els_p`, 8, vectors per register file
- `vlen_p`, 8, elements per vector
- `vdw_p`, 8, bits per element
- `lanes_p`, 4, number of lanes (`vlen_p % lanes_p == 0`)
- `op_width_p`, 4, opcode width
- Derived: `v_addr_width_lp = BSG_SAFE_CLOG2(els_p)`, `local_addr_width_lp = BSG_SAFE_CLOG2(vlen_p)`, `beats_lp = vlen_p/lanes_p`
- `clk_i`  in  1  sole clock, rising edge
- `reset_i`  in  1  asynchronous, active-high reset
- `instr_v_i`  in  1  instruction valid
- `instr_ready_o`  out  1  high only in IDLE
- `instr_op_i`  in  op_width_p  opcode
- `instr_vd_i`, `instr_vs1_i`, `instr_vs2_i`  in  v_addr_width_lp each  destination / source vector indices
- `instr_offset_i`  in  local_addr_width_lp  FMA write offset
- `instr_scalar_i`, `instr_wdata_i`  in  vdw_p each  scalar operand / external write data
- `op_o`  out  op_width_p  opcode to all lanes
- `start_o`  out  1  one-cycle start pulse to all lanes
- `w_addr_offset_o`  out  local_addr_width_lp  to lanes
- `scalar_o`, `w_data_o`  out  vdw_p each  to lanes
- `vd_o`, `vs1_o`, `vs2_o`  out  v_addr_width_lp each  regfile vector selects
- `lane_done_i`  in  lanes_p  per-lane done pulses
- `lane_v_i`  in  lanes_p  per-lane read-data valid
- `lane_r_data_i`  in  lanes_p*vdw_p  lane i occupies `[i*vdw_p +: vdw_p]`
- `resp_v_o`  out  1  response valid
- `resp_data_o`  out  vlen_p*vdw_p  element e at `[e*vdw_p +: vdw_p]`
- `resp_yumi_i`  in  1  response consumed

## Operation
- Registered FSM with states IDLE, ISSUE, BUSY and RESP.
- **IDLE**
  - `instr_ready_o=1`.
  - On `instr_v_i` the controller latches all instruction fields into the operand registers and moves to ISSUE.
  - It clears the done mask, beat counter and result buffer.
- **ISSUE** (exactly 1 cycle)
  - `start_o=1`, then the FSM moves to BUSY.
- **BUSY**
  - Each cycle: `mask <= mask | lane_done_i`.
  - When `(mask | lane_done_i)` is all ones, the FSM moves to RESP. Lanes finishing in the same cycle or different cycles are both legal.
- **RESP**
  - `resp_v_o=1` and `resp_data_o` is held stable.
  - On `resp_yumi_i` the FSM returns to IDLE. No new instruction is accepted in the same cycle.
- **Operand hold**
  - `op_o`, `vd_o`, `vs1_o`, `vs2_o`, `w_addr_offset_o`, `scalar_o` and `w_data_o` are driven from the operand registers.
  - They are stable from ISSUE through the end of RESP, because lanes decode `op_i` combinationally every cycle.
- **Read collection** (latched op == 4'b1000, states ISSUE/BUSY only)
  - On a cycle with `lane_v_i[0]` and `beat < beats_lp`, write `lane_r_data_i[i]` to element `i + lanes_p*beat` for each lane i, then `beat++`.
  - Beats beyond `beats_lp` are ignored.
  - `lane_v_i[0]` is the reference; lanes run in lockstep, so the other bits are unused for indexing.
- **Non-read ops**
  - `resp_data_o` is all zeros.
- **Ignored inputs**
  - `lane_done_i` and `lane_v_i` are ignored in IDLE and RESP.

## Timing
- **Reset values** (asynchronous on assertion, synchronous on release)
  - State is IDLE, so `instr_ready_o=1`.
  - `start_o=0`, `resp_v_o=0`, `resp_data_o=0`.
  - All operand outputs are 0, mask is 0, beat is 0.
- **Handshake timing**
  - Accept at edge T, then `start_o` is high in cycle T+1.
  - The earliest `resp_v_o` is one cycle after the final done bit is seen.
  - Response latency is set by the lanes; the controller adds 1 cycle of issue and 1 cycle of mask-to-RESP.
- **Reset mid-operation**
  - The controller aborts to IDLE immediately and discards partial mask and result.
  - No response is emitted for the aborted instruction.
- `instr_v_i` while not ready: the instruction is not latched and the upstream holds it.
- `resp_yumi_i` outside RESP: ignored.

## Test plan
All scenarios use lanes_p=4, vlen_p=8, vdw_p=8.

- **Reset**
  - Stimulus: assert `reset_i` asynchronously mid-cycle in BUSY.
  - Required: `instr_ready_o=1`, `start_o=0` and `resp_v_o=0` before the next edge; the next instruction issues normally.
- **Non-read op**
  - Stimulus: accept op 4'b0000 with vd=3, vs1=1, vs2=2; lanes pulse done in cycles T+5, T+5, T+6, T+7.
  - Required: `start_o` high only in T+1, `vd_o=3` held through RESP, `resp_v_o` rises at T+8, `resp_data_o=0`.
- **Read op**
  - Stimulus: op 4'b1000; two beats with lane i presenting `0x10*beat+i`, then all done in the same cycle.
  - Required: `resp_data_o` elements 0..7 = 00,01,02,03,10,11,12,13; a spurious third beat does not change them.
- **Back-pressure**
  - Stimulus: hold `resp_yumi_i=0` for 5 cycles in RESP while `instr_v_i=1`.
  - Required: `resp_v_o` and data stay stable and `instr_ready_o=0`; after yumi, IDLE, then the next instruction is accepted the following cycle.
- **Stray done**
  - Stimulus: pulse `lane_done_i=4'b1111` in IDLE, then issue an instruction.
  - Required: the instruction is not completed early and the mask starts at 0.
- **FMA**
  - Stimulus: op 4'b1111 with offset=2, scalar=0x05.
  - Required: `w_addr_offset_o=2` and `scalar_o=0x05` stable from ISSUE to RESP; the response follows all four done bits.
